reg_file: RTL and testbench

Two-read, one-write general-purpose register file for the MyProc2 pipeline. It is the responder side of the decode-stage register-read handshake: decode drives an address and enable per read port, and this block returns the operand data plus a one-cycle strobe whose rising edge tells decode the data is valid. The single write port is driven by write-back and acknowledged the same way. Register 0 is hard-wired to zero.

---
 rtl/reg_file_if.sv | 33 +++
 rtl/reg_file.sv | 101 ++++++++++
 tb/tb_reg_file.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_if : decode/write-back handshake bundle for the register file
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface reg_file_if #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic [REG_ADDR_LEN-1:0] Rd1_addr;
  logic                    Rd1_en;
  logic [WIDTH-1:0]        Rd1_data;
  logic                    Rd1_st;
  logic [REG_ADDR_LEN-1:0] Rd2_addr;
  logic                    Rd2_en;
  logic [WIDTH-1:0]        Rd2_data;
  logic                    Rd2_st;
  logic [REG_ADDR_LEN-1:0] Wr_addr;
  logic [WIDTH-1:0]        Wr_data;
  logic                    Wr_en;
  logic                    Wr_st;

  modport master (
    output Rd1_addr, Rd1_en, Rd2_addr, Rd2_en, Wr_addr, Wr_data, Wr_en,
    input  Rd1_data, Rd1_st, Rd2_data, Rd2_st, Wr_st
  );

  modport slave (
    input  Rd1_addr, Rd1_en, Rd2_addr, Rd2_en, Wr_addr, Wr_data, Wr_en,
    output Rd1_data, Rd1_st, Rd2_data, Rd2_st, Wr_st
  );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file : 2-read / 1-write register file, r0 hard-wired to zero,
//            strobed handshake on every port
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input wire logic  clk,
  input wire logic  rst_n,
  reg_file_if.slave bus
);
  localparam int c_DEPTH = 1 << REG_ADDR_LEN;
  localparam int c_PORTS = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_HOLD = 2'd2
  } rd_state_t;

  logic [WIDTH-1:0]        r_regs [c_DEPTH];
  logic                    r_wr_st;
  logic [REG_ADDR_LEN-1:0] w_rd_addr [c_PORTS];
  logic                    w_rd_en   [c_PORTS];
  logic [WIDTH-1:0]        w_rd_data [c_PORTS];
  logic                    w_rd_st   [c_PORTS];

  assign w_rd_addr[0] = bus.Rd1_addr;
  assign w_rd_addr[1] = bus.Rd2_addr;
  assign w_rd_en[0]   = bus.Rd1_en;
  assign w_rd_en[1]   = bus.Rd2_en;

  // Writes to r0 are dropped but still acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= '0;
      r_wr_st <= 1'b0;
    end else begin
      r_wr_st <= bus.Wr_en;
      if (bus.Wr_en && (bus.Wr_addr != '0)) r_regs[bus.Wr_addr] <= bus.Wr_data;
    end
  end

  for (genvar p = 0; p < c_PORTS; p++) begin : g_rd_port
    rd_state_t               r_state;
    logic [REG_ADDR_LEN-1:0] r_lat_addr;
    logic [WIDTH-1:0]        r_data;
    logic                    r_st;
    logic [WIDTH-1:0]        w_fetch;
    logic                    w_accept;

    // Same-edge write to the requested register is forwarded.
    always_comb begin
      w_fetch = r_regs[w_rd_addr[p]];
      if (w_rd_addr[p] == '0)
        w_fetch = '0;
      else if (bus.Wr_en && (bus.Wr_addr == w_rd_addr[p]))
        w_fetch = bus.Wr_data;
    end

    assign w_accept = w_rd_en[p] &&
                      ((r_state == S_IDLE) ||
                       ((r_state == S_HOLD) && (w_rd_addr[p] != r_lat_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= S_IDLE;
        r_lat_addr <= '0;
        r_data     <= '0;
        r_st       <= 1'b0;
      end else begin
        r_st <= w_accept;
        if (w_accept) begin
          r_lat_addr <= w_rd_addr[p];
          r_data     <= w_fetch;
          r_state    <= S_ACK;
        end else begin
          case (r_state)
            S_IDLE:  r_state <= S_IDLE;
            S_ACK:   r_state <= S_HOLD;
            S_HOLD:  if (!w_rd_en[p]) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end

    assign w_rd_data[p] = r_data;
    assign w_rd_st[p]   = r_st;
  end

  assign bus.Rd1_data = w_rd_data[0];
  assign bus.Rd1_st   = w_rd_st[0];
  assign bus.Rd2_data = w_rd_data[1];
  assign bus.Rd2_st   = w_rd_st[1];
  assign bus.Wr_st    = r_wr_st;
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_file : directed self-checking bench for reg_file
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_reg_file;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_file_if #(.WIDTH(32), .REG_ADDR_LEN(5)) bus ();

  reg_file #(.WIDTH(32), .REG_ADDR_LEN(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reads();
    bus.Rd1_en = 1'b0;
    bus.Rd2_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.Rd1_addr = '0; bus.Rd1_en = 1'b0;
    bus.Rd2_addr = '0; bus.Rd2_en = 1'b0;
    bus.Wr_addr  = '0; bus.Wr_data = '0; bus.Wr_en = 1'b0;
    #1;
    check("rst_rd1_data", bus.Rd1_data, 32'h0);
    check("rst_rd1_st",   {31'b0, bus.Rd1_st}, 32'h0);
    check("rst_rd2_data", bus.Rd2_data, 32'h0);
    check("rst_rd2_st",   {31'b0, bus.Rd2_st}, 32'h0);
    check("rst_wr_st",    {31'b0, bus.Wr_st}, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Reset then read r5
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd5;
    step();
    check("r5_st_ack",   {31'b0, bus.Rd1_st}, 32'h1);
    check("r5_data_ack", bus.Rd1_data, 32'h0);
    step();
    check("r5_st_hold1", {31'b0, bus.Rd1_st}, 32'h0);
    step();
    check("r5_st_hold2", {31'b0, bus.Rd1_st}, 32'h0);
    clear_reads();

    // Write r7 then dual read
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd7; bus.Wr_data = 32'hDEADBEEF;
    step();
    check("w7_wr_st", {31'b0, bus.Wr_st}, 32'h1);
    bus.Wr_en = 1'b0;
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd7;
    bus.Rd2_en = 1'b1; bus.Rd2_addr = 5'd7;
    step();
    check("w7_wr_st_low", {31'b0, bus.Wr_st}, 32'h0);
    check("dual_rd1_st",   {31'b0, bus.Rd1_st}, 32'h1);
    check("dual_rd2_st",   {31'b0, bus.Rd2_st}, 32'h1);
    check("dual_rd1_data", bus.Rd1_data, 32'hDEADBEEF);
    check("dual_rd2_data", bus.Rd2_data, 32'hDEADBEEF);
    clear_reads();

    // Bypass to both ports on the write edge
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd3; bus.Wr_data = 32'h12345678;
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd3;
    bus.Rd2_en = 1'b1; bus.Rd2_addr = 5'd3;
    step();
    check("byp_rd1_data", bus.Rd1_data, 32'h12345678);
    check("byp_rd2_data", bus.Rd2_data, 32'h12345678);
    check("byp_rd1_st",   {31'b0, bus.Rd1_st}, 32'h1);
    check("byp_wr_st",    {31'b0, bus.Wr_st}, 32'h1);
    bus.Wr_en = 1'b0;
    clear_reads();

    // r0: write with concurrent read, then plain read
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd0; bus.Wr_data = 32'hFFFFFFFF;
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd0;
    step();
    check("r0_wr_st",      {31'b0, bus.Wr_st}, 32'h1);
    check("r0_byp_data",   bus.Rd1_data, 32'h0);
    bus.Wr_en = 1'b0;
    clear_reads();
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd0;
    step();
    check("r0_rd_st",   {31'b0, bus.Rd1_st}, 32'h1);
    check("r0_rd_data", bus.Rd1_data, 32'h0);
    clear_reads();

    // Two back-to-back writes keep Wr_st high
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd4; bus.Wr_data = 32'h4;
    step();
    check("bb_wr_st1", {31'b0, bus.Wr_st}, 32'h1);
    bus.Wr_addr = 5'd9; bus.Wr_data = 32'h9;
    step();
    check("bb_wr_st2", {31'b0, bus.Wr_st}, 32'h1);
    bus.Wr_en = 1'b0;
    step();
    check("bb_wr_st_low", {31'b0, bus.Wr_st}, 32'h0);

    // Address change in HOLD
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd4;
    step();
    check("chg_st_a",   {31'b0, bus.Rd1_st}, 32'h1);
    check("chg_data_a", bus.Rd1_data, 32'h4);
    step();
    check("chg_hold_a", {31'b0, bus.Rd1_st}, 32'h0);
    bus.Rd1_addr = 5'd9;
    step();
    check("chg_st_b",   {31'b0, bus.Rd1_st}, 32'h1);
    check("chg_data_b", bus.Rd1_data, 32'h9);
    step();
    check("chg_hold_b", {31'b0, bus.Rd1_st}, 32'h0);
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd9; bus.Wr_data = 32'h99;
    step();
    bus.Wr_en = 1'b0;
    check("chg_no_restrobe", {31'b0, bus.Rd1_st}, 32'h0);
    check("chg_data_stable", bus.Rd1_data, 32'h9);
    step();
    check("chg_no_restrobe2", {31'b0, bus.Rd1_st}, 32'h0);
    clear_reads();

    // Async reset while Rd1 is in ACK
    bus.Rd1_en = 1'b1; bus.Rd1_addr = 5'd7;
    step();
    check("ar_st_before",   {31'b0, bus.Rd1_st}, 32'h1);
    check("ar_data_before", bus.Rd1_data, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_st_now",   {31'b0, bus.Rd1_st}, 32'h0);
    check("ar_data_now", bus.Rd1_data, 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    check("ar_reaccept_st", {31'b0, bus.Rd1_st}, 32'h1);
    check("ar_r7_cleared",  bus.Rd1_data, 32'h0);
    clear_reads();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
